// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the fifo_ext queue family.
package fifo_pkg;

    localparam int DEF_WIDTH = 32'sd2;
    localparam int DEF_DEPTH = 32'sd4;

    // Pointer width; a one-entry degenerate case still needs one address bit.
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
    endfunction

    // Occupancy width: one extra bit so that DEPTH itself is representable.
    function automatic int fifo_cnt_w(input int depth);
        return fifo_ptr_w(depth) + 32'sd1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [fifo_ptr_w(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic [fifo_ptr_w(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]             rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_ext.sv
// Parametrised show-ahead single-clock FIFO with occupancy, almost-full and sticky error flags.
// Optional high-water mark register enabled by defining FIFO_PEAK_EN.
module fifo_ext
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 32'sd1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             in,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clr_err,
    output logic [WIDTH-1:0]             out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic [fifo_cnt_w(DEPTH)-1:0] count,
    output logic                         overflow,
    output logic                         underflow,
    output logic [fifo_cnt_w(DEPTH)-1:0] peak
);

    localparam int PTR_W = fifo_ptr_w(DEPTH);
    localparam int CNT_W = fifo_cnt_w(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             full_s, empty_s;
    logic             do_push_s, do_pop_s;
    logic             ovf_set_s, udf_set_s;
    logic [WIDTH-1:0] rdata_s;

    // Request qualification and next-state computation; flags come from count_q only.
    always_comb begin
        full_s    = (count_q == CNT_FULL);
        empty_s   = (count_q == CNT_ZERO);
        // A push into a full FIFO is still accepted when a pop frees the head slot.
        do_push_s = push && (!full_s || pop);
        do_pop_s  = pop && !empty_s;
        ovf_set_s = push && full_s && !pop;
        udf_set_s = pop && empty_s;

        wr_ptr_d = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = do_pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        if (do_push_s && !do_pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop_s && !do_push_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end

        // A fresh error event outranks a simultaneous clear.
        if (ovf_set_s) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (udf_set_s) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Pointer, occupancy and sticky error state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (do_push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (in),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_s)
    );

    assign out         = empty_s ? '0 : rdata_s;
    assign full        = full_s;
    assign empty       = empty_s;
    assign almost_full = (count_q >= CNT_AF);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

`ifdef FIFO_PEAK_EN
    logic [CNT_W-1:0] peak_q, peak_d;

    // High-water mark follows the occupancy the FIFO is about to hold.
    always_comb begin
        if (clr_err) begin
            peak_d = CNT_ZERO;
        end else if (count_d > peak_q) begin
            peak_d = count_d;
        end else begin
            peak_d = peak_q;
        end
    end

    // High-water mark register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`else
    assign peak = CNT_ZERO;
`endif

endmodule

// File: tb/tb_fifo_ext.sv
// Directed self-checking bench for fifo_ext (WIDTH=2, DEPTH=4, AF_LEVEL=3).
module tb_fifo_ext;

    logic       clk;
    logic       reset;
    logic [1:0] in;
    logic       push;
    logic       pop;
    logic       clr_err;
    logic [1:0] out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;
    logic [2:0] peak;

    int n_cmp;
    int n_bad;

    fifo_ext #(
        .WIDTH    (2),
        .DEPTH    (4),
        .AF_LEVEL (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .push        (push),
        .pop         (pop),
        .clr_err     (clr_err),
        .out         (out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .peak        (peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given requests, then inputs return idle; sampling happens 1ns after the edge.
    task automatic step(input logic p_push, input logic p_pop, input logic [1:0] p_in, input logic p_clr);
        push    = p_push;
        pop     = p_pop;
        in      = p_in;
        clr_err = p_clr;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        in      = 2'd0;
        clr_err = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [1:0] e_out, input logic [2:0] e_cnt,
                               input logic e_ovf, input logic e_udf);
        check({tag, ".out"},   32'(out),         32'(e_out));
        check({tag, ".count"}, 32'(count),       32'(e_cnt));
        check({tag, ".empty"}, 32'(empty),       32'(e_cnt == 3'd0));
        check({tag, ".full"},  32'(full),        32'(e_cnt == 3'd4));
        check({tag, ".af"},    32'(almost_full), 32'(e_cnt >= 3'd3));
        check({tag, ".ovf"},   32'(overflow),    32'(e_ovf));
        check({tag, ".udf"},   32'(underflow),   32'(e_udf));
    endtask

    initial begin
        logic [2:0] exp_peak;
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        in      = 2'd0;
        clr_err = 1'b0;

        #12;
        check_state("in_reset", 2'd0, 3'd0, 1'b0, 1'b0);
        check("in_reset.peak", 32'(peak), 32'd0);
        reset = 1'b1;
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check_state("idle", 2'd0, 3'd0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 2'd0, 1'b0);
        check_state("pop_empty", 2'd0, 3'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 2'd0, 1'b1);
        check_state("clr_udf", 2'd0, 3'd0, 1'b0, 1'b0);

        step(1'b1, 1'b0, 2'd3, 1'b0);
        check_state("push3", 2'd3, 3'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd0, 1'b0);
        check_state("pop1", 2'd0, 3'd0, 1'b0, 1'b0);

        step(1'b1, 1'b0, 2'd1, 1'b0);
        check_state("fill1", 2'd1, 3'd1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd2, 1'b0);
        check_state("fill2", 2'd1, 3'd2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd3, 1'b0);
        check_state("fill3", 2'd1, 3'd3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd3, 1'b0);
        check_state("fill4", 2'd1, 3'd4, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd2, 1'b0);
        check_state("push_full", 2'd1, 3'd4, 1'b1, 1'b0);
`ifdef FIFO_PEAK_EN
        exp_peak = 3'd4;
`else
        exp_peak = 3'd0;
`endif
        check("peak_after_fill", 32'(peak), 32'(exp_peak));
        step(1'b0, 1'b0, 2'd0, 1'b1);
        check_state("clr_ovf", 2'd1, 3'd4, 1'b0, 1'b0);

        step(1'b1, 1'b1, 2'd0, 1'b0);
        check_state("pushpop_full", 2'd2, 3'd4, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd0, 1'b0);
        check_state("drain1", 2'd3, 3'd3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd0, 1'b0);
        check_state("drain2", 2'd3, 3'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd0, 1'b0);
        check_state("drain3", 2'd0, 3'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd0, 1'b0);
        check_state("drain4", 2'd0, 3'd0, 1'b0, 1'b0);

        step(1'b1, 1'b1, 2'd1, 1'b0);
        check_state("pushpop_empty", 2'd1, 3'd1, 1'b0, 1'b1);

        // Asynchronous reset away from any clock edge.
        #2;
        reset = 1'b0;
        #1;
        check_state("async_rst", 2'd0, 3'd0, 1'b0, 1'b0);
        check("async_rst.peak", 32'(peak), 32'd0);

        // Requests while held in reset must be ignored.
        step(1'b1, 1'b0, 2'd2, 1'b0);
        check_state("req_in_rst", 2'd0, 3'd0, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b1, 1'b0, 2'd2, 1'b0);
        check_state("post_rst_push", 2'd2, 3'd1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
